// File: rtl/game_control_gen_pkg.sv
// Shared types and constants for the racing-game sequencer: state encoding,
// HID key codes, and the winner priority encoder.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        MENU,
        COUNT,
        GO,
        ARM,
        PLAY,
        PAUSED,
        WIN
    } game_state_e;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_PAUSE = 8'h13;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_DRIVE = 8'h16;

    localparam int MAX_PLAYERS = 8;

    // The lowest set index wins when several players finish on the same cycle.
    function automatic logic [2:0] win_index(input logic [MAX_PLAYERS-1:0] w);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
            if (w[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/game_control_gen_if.sv
// Signal bundle between the keyboard/race logic and the game sequencer.
interface game_control_gen_if
    import game_ctrl_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int COUNT_FROM = 3,
    parameter int MAX_LEVEL  = 8,
    parameter int SPEED_W    = 10
);
    // No valid/ready handshake: keycode and win are sampled every cycle as
    // level signals, and every output is a continuous, registered-state decode.
    logic [7:0]                       keycode;
    logic [N_PLAYERS-1:0]             win;
    logic                             show_menu;
    logic                             show_count;
    logic [$clog2(COUNT_FROM+1)-1:0]  count_val;
    logic                             show_go;
    logic                             paused;
    logic [N_PLAYERS-1:0]             show_win;
    logic [$clog2(MAX_LEVEL+1)-1:0]   level;
    logic [SPEED_W-1:0]               traffic_step_size;
    logic [SPEED_W-1:0]               tree_step_size;
    logic [7:0]                       keycode_control;
    game_state_e                      state;

    modport master (
        output keycode, win,
        input  show_menu, show_count, count_val, show_go, paused, show_win,
               level, traffic_step_size, tree_step_size, keycode_control, state
    );

    modport slave (
        input  keycode, win,
        output show_menu, show_count, count_val, show_go, paused, show_win,
               level, traffic_step_size, tree_step_size, keycode_control, state
    );

endinterface

// File: rtl/game_control_gen_key_edge_det.sv
// Registers the previous keycode and emits a one-cycle pulse per watched key
// on the cycle that key first appears.
module key_edge_det #(
    parameter int                  N_KEYS = 1,
    parameter logic [8*N_KEYS-1:0] KEYS   = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        keycode,
    output logic [N_KEYS-1:0] pulse
);
    logic [7:0] prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) prev <= '0;
        else       prev <= keycode;
    end

    always_comb begin
        pulse = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            pulse[i] = (keycode == KEYS[8*i +: 8]) && (prev != KEYS[8*i +: 8]);
        end
    end

endmodule

// File: rtl/game_control_gen.sv
// Game sequencer: menu, countdown, GO, play with speed ramp and pause,
// winner banner, back to menu.
module game_control_gen
    import game_ctrl_pkg::*;
#(
    parameter int N_PLAYERS    = 2,
    parameter int COUNT_FROM   = 3,
    parameter int TICK_CYCLES  = 50_000_000,
    parameter int LEVEL_CYCLES = 1_800_000_000,
    parameter int WIN_CYCLES   = 800_000_000,
    parameter int MAX_LEVEL    = 8,
    parameter int SPEED_W      = 10,
    parameter int TRAFFIC_INC  = 2,
    parameter int TREE_INC     = 4,
    parameter int CNT_W        = 32
) (
    input logic              Clk,
    input logic              Reset,
    game_control_gen_if.slave bus
);
    localparam int CV_W  = $clog2(COUNT_FROM + 1);
    localparam int LVL_W = $clog2(MAX_LEVEL + 1);
    localparam logic [CNT_W-1:0]     TICK_M1  = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0]     LEVEL_M1 = CNT_W'(LEVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]     WIN_M1   = CNT_W'(WIN_CYCLES - 1);
    localparam logic [SPEED_W-1:0]   T_INC    = SPEED_W'(TRAFFIC_INC);
    localparam logic [SPEED_W-1:0]   R_INC    = SPEED_W'(TREE_INC);
    localparam logic [LVL_W-1:0]     LVL_MAX  = LVL_W'(MAX_LEVEL);
    localparam logic [N_PLAYERS-1:0] WIN_ONE  = N_PLAYERS'(1);

    if (MAX_LEVEL * TREE_INC >= 2 ** SPEED_W) begin : g_bad_speed_w
        $error("SPEED_W too narrow for MAX_LEVEL*TREE_INC");
    end
    if (TICK_CYCLES == 0 || LEVEL_CYCLES == 0 || WIN_CYCLES == 0) begin : g_bad_cycles
        $error("cycle parameters must be non-zero");
    end
    if (N_PLAYERS < 2 || N_PLAYERS > MAX_PLAYERS || MAX_LEVEL < 1) begin : g_bad_range
        $error("N_PLAYERS must be 2..8 and MAX_LEVEL >= 1");
    end

    game_state_e        state, state_d;
    logic [CNT_W-1:0]   timer;
    logic [CV_W-1:0]    cnt;
    logic [LVL_W-1:0]   level_q, level_inc;
    logic [SPEED_W-1:0] traffic_q, tree_q;
    logic [2:0]         winner;
    logic [2:0]         edges;
    logic               enter_edge, pause_edge, esc_edge, any_win;
    logic               tick_done, level_done, win_done;

    key_edge_det #(
        .N_KEYS(3),
        .KEYS  ({KEY_ESC, KEY_PAUSE, KEY_ENTER})
    ) u_keys (
        .Clk    (Clk),
        .Reset  (Reset),
        .keycode(bus.keycode),
        .pulse  (edges)
    );

    assign enter_edge = edges[0];
    assign pause_edge = edges[1];
    assign esc_edge   = edges[2];
    assign any_win    = |bus.win;
    assign tick_done  = (timer == TICK_M1);
    assign level_done = (timer == LEVEL_M1);
    assign win_done   = (timer == WIN_M1);
    assign level_inc  = (level_q == LVL_MAX) ? level_q : level_q + LVL_W'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= MENU;
        else       state <= state_d;
    end

    // Win is checked before pause in PLAY; ESC is checked before PAUSE in PAUSED.
    always_comb begin
        state_d = state;
        case (state)
            MENU:    if (enter_edge) state_d = COUNT;
            COUNT:   if (tick_done && cnt == CV_W'(1)) state_d = GO;
            GO:      if (tick_done) state_d = ARM;
            ARM:     state_d = PLAY;
            PLAY:    if (any_win) state_d = WIN;
                     else if (pause_edge) state_d = PAUSED;
            PAUSED:  if (esc_edge) state_d = MENU;
                     else if (pause_edge) state_d = PLAY;
            WIN:     if (win_done) state_d = MENU;
            default: state_d = MENU;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            timer     <= '0;
            cnt       <= CV_W'(COUNT_FROM);
            level_q   <= '0;
            traffic_q <= '0;
            tree_q    <= '0;
            winner    <= '0;
        end else begin
            case (state)
                MENU: if (enter_edge) begin
                    timer <= '0;
                    cnt   <= CV_W'(COUNT_FROM);
                end
                COUNT: if (tick_done) begin
                    timer <= '0;
                    if (cnt != CV_W'(1)) cnt <= cnt - CV_W'(1);
                end else begin
                    timer <= timer + CNT_W'(1);
                end
                GO: timer <= tick_done ? '0 : timer + CNT_W'(1);
                ARM: begin
                    timer     <= '0;
                    level_q   <= LVL_W'(1);
                    traffic_q <= T_INC;
                    tree_q    <= R_INC;
                end
                // A pause edge freezes the timer on that cycle so resume
                // continues from exactly the value seen when pausing.
                PLAY: if (any_win) begin
                    winner <= win_index(MAX_PLAYERS'(bus.win));
                    timer  <= '0;
                end else if (!pause_edge) begin
                    if (level_done) begin
                        timer     <= '0;
                        level_q   <= level_inc;
                        traffic_q <= SPEED_W'(level_inc) * T_INC;
                        tree_q    <= SPEED_W'(level_inc) * R_INC;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                PAUSED: if (esc_edge) begin
                    timer     <= '0;
                    level_q   <= '0;
                    traffic_q <= '0;
                    tree_q    <= '0;
                end
                WIN: if (win_done) begin
                    timer     <= '0;
                    level_q   <= '0;
                    traffic_q <= '0;
                    tree_q    <= '0;
                end else begin
                    timer <= timer + CNT_W'(1);
                end
                default: timer <= '0;
            endcase
        end
    end

    always_comb begin
        bus.show_menu       = 1'b0;
        bus.show_count      = 1'b0;
        bus.count_val       = '0;
        bus.show_go         = 1'b0;
        bus.paused          = 1'b0;
        bus.show_win        = '0;
        bus.keycode_control = '0;
        case (state)
            MENU:      bus.show_menu = 1'b1;
            COUNT: begin
                bus.show_count = 1'b1;
                bus.count_val  = cnt;
            end
            GO:        bus.show_go = 1'b1;
            ARM, PLAY: bus.keycode_control = KEY_DRIVE;
            PAUSED:    bus.paused = 1'b1;
            WIN:       bus.show_win = WIN_ONE << winner;
            default:   bus.show_menu = 1'b0;
        endcase
    end

    assign bus.level             = level_q;
    assign bus.traffic_step_size = traffic_q;
    assign bus.tree_step_size    = tree_q;
    assign bus.state             = state;

endmodule
